// File: rtl/keypad_4x4_scan.sv
`default_nettype none
// ============================================================================
// Module   : keypad_4x4_scan
// Purpose  : 4x4 matrix keypad scanner with frame debounce and valid/ack
//            handshake. Optional macro KEYPAD_OVERRUN_EN enables the sticky
//            lost-event flag; otherwise overrun is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_4x4_scan #(
  parameter int PRE = 14,
  parameter int DEB = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       pressed,
  output logic       overrun
);

  localparam logic [2:0] c_deb = 3'(DEB);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  logic [PRE:0] r_pre_cnt;
  logic [3:0]   r_col_s1;
  logic [3:0]   r_col_s2;
  logic [1:0]   r_row_idx;
  logic         r_acc_hit;
  logic [3:0]   r_acc_code;
  state_t       r_state;
  state_t       w_state_n;
  logic [2:0]   r_count;
  logic [2:0]   w_count_n;
  logic [2:0]   w_cnt_inc;
  logic [3:0]   r_candidate;
  logic [3:0]   w_candidate_n;
  logic [3:0]   r_key;
  logic [3:0]   w_key_n;
  logic         r_key_valid;
  logic         w_key_valid_n;
  logic         r_pressed;
  logic         w_pressed_n;
  logic         w_accept;

  logic         w_tick;
  logic         w_frame_end;
  logic [3:0]   w_col_low;
  logic         w_col_any;
  logic [1:0]   w_col_idx;
  logic         w_frame_hit;
  logic [3:0]   w_frame_code;

  assign w_tick      = r_pre_cnt[PRE];
  assign w_frame_end = w_tick && (r_row_idx == 2'd3);
  assign w_col_low   = ~r_col_s2;
  assign w_col_any   = |w_col_low;
  assign row         = ~(4'b0001 << r_row_idx);

  // Lowest-index low column wins within the current row
  always_comb begin
    w_col_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_col_low[i]) w_col_idx = 2'(i);
    end
  end

  assign w_frame_hit  = r_acc_hit | w_col_any;
  assign w_frame_code = r_acc_hit ? r_acc_code : {r_row_idx, w_col_idx};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre_cnt  <= '0;
      r_col_s1   <= 4'b1111;
      r_col_s2   <= 4'b1111;
      r_row_idx  <= 2'd0;
      r_acc_hit  <= 1'b0;
      r_acc_code <= 4'd0;
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + (PRE+1)'(1);
      r_col_s1  <= col;
      r_col_s2  <= r_col_s1;
      if (w_tick) begin
        r_row_idx <= r_row_idx + 2'd1;
        if (w_frame_end) begin
          r_acc_hit  <= 1'b0;
          r_acc_code <= 4'd0;
        end else if (!r_acc_hit && w_col_any) begin
          r_acc_hit  <= 1'b1;
          r_acc_code <= {r_row_idx, w_col_idx};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_count     <= 3'd0;
      r_candidate <= 4'd0;
      r_key       <= 4'd0;
      r_key_valid <= 1'b0;
      r_pressed   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_count     <= w_count_n;
      r_candidate <= w_candidate_n;
      r_key       <= w_key_n;
      r_key_valid <= w_key_valid_n;
      r_pressed   <= w_pressed_n;
    end
  end

  // Count is zero in IDLE and HELD, so DEB=1 falls straight through the DB states
  assign w_cnt_inc = r_count + 3'd1;

  always_comb begin
    w_state_n     = r_state;
    w_count_n     = r_count;
    w_candidate_n = r_candidate;
    w_key_n       = r_key;
    w_pressed_n   = r_pressed;
    w_accept      = 1'b0;
    w_key_valid_n = r_key_valid & ~key_ack;
    if (w_frame_end) begin
      case (r_state)
        IDLE: begin
          if (w_frame_hit) begin
            w_candidate_n = w_frame_code;
            if (w_cnt_inc >= c_deb) begin
              w_accept  = 1'b1;
              w_state_n = HELD;
              w_count_n = 3'd0;
            end else begin
              w_state_n = DB_PRESS;
              w_count_n = w_cnt_inc;
            end
          end
        end
        DB_PRESS: begin
          if (w_frame_hit && (w_frame_code == r_candidate)) begin
            if (w_cnt_inc >= c_deb) begin
              w_accept  = 1'b1;
              w_state_n = HELD;
              w_count_n = 3'd0;
            end else begin
              w_count_n = w_cnt_inc;
            end
          end else begin
            w_state_n = IDLE;
            w_count_n = 3'd0;
          end
        end
        HELD: begin
          if (!w_frame_hit) begin
            if (w_cnt_inc >= c_deb) begin
              w_state_n   = IDLE;
              w_count_n   = 3'd0;
              w_pressed_n = 1'b0;
            end else begin
              w_state_n = DB_RELEASE;
              w_count_n = w_cnt_inc;
            end
          end
        end
        DB_RELEASE: begin
          if (w_frame_hit) begin
            w_state_n = HELD;
            w_count_n = 3'd0;
          end else if (w_cnt_inc >= c_deb) begin
            w_state_n   = IDLE;
            w_count_n   = 3'd0;
            w_pressed_n = 1'b0;
          end else begin
            w_count_n = w_cnt_inc;
          end
        end
        default: begin
          w_state_n = IDLE;
          w_count_n = 3'd0;
        end
      endcase
    end
    if (w_accept) begin
      w_key_n       = w_frame_code;
      w_pressed_n   = 1'b1;
      w_key_valid_n = 1'b1;
    end
  end

  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign pressed   = r_pressed;

`ifdef KEYPAD_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (w_accept && r_key_valid && !key_ack) begin
      r_overrun <= 1'b1;
    end else if (key_ack && r_key_valid) begin
      r_overrun <= 1'b0;
    end
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/keypad_4x4_scan.md
KEYPAD_4X4_SCAN -- requirements
Module: keypad_4x4_scan

Interface
REQ-001 Parameter PRE, default 14: scan tick every 2^PRE+1 clk cycles (prescaler bit PRE set).
REQ-002 Parameter DEB, default 3: consecutive identical scan frames needed to accept a press or release (1..7).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 col  input  4  keypad column sense lines, active-low (pulled up externally), asynchronous to clk.
REQ-006 row  output  4  keypad row drive lines, active-low, exactly one row low at a time.
REQ-007 key  output  4  accepted key code = row_index*4 + col_index.
REQ-008 key_valid  output  1  accepted-key event pending, held until acknowledged.
REQ-009 key_ack  input  1  consumer acknowledge, single-cycle or level.
REQ-010 pressed  output  1  debounced key-down level.
REQ-011 overrun  output  1  sticky lost-event flag (see Configuration).

Function
REQ-012 Prescaler pre_cnt[PRE:0] increments each clk, clears when bit PRE set; tick = pre_cnt[PRE].
REQ-013 col passes through a 2-flop synchronizer before any use.
REQ-014 Row index r[1:0] advances 0,1,2,3,0 on each tick; row = ~(4'b0001 << r).
REQ-015 On tick, synchronized col is sampled for current r before r advances; first low column (lowest index) in scan order (r=0 first) becomes frame code; later hits in same frame ignored.
REQ-016 Frame ends on tick sampling r=3; frame result = {hit, code}; frame accumulator clears for next frame.
REQ-017 FSM states IDLE, DB_PRESS, HELD, DB_RELEASE; transitions evaluated only at frame end.
REQ-018 IDLE: hit -> DB_PRESS, candidate=code, count=1; no hit -> stay.
REQ-019 DB_PRESS: hit with same code -> count+1; count reaching DEB -> HELD; no hit or different code -> IDLE, count=0.
REQ-020 Entry to HELD: key<=candidate, pressed<=1, key_valid<=1, all registered on the clk after the frame-end tick.
REQ-021 HELD: any hit -> stay (code change while held ignored); no hit -> DB_RELEASE, count=1.
REQ-022 DB_RELEASE: no hit -> count+1, count reaching DEB -> IDLE, pressed<=0; hit -> HELD, count=0.
REQ-023 DEB=1: single frame accepts press/release, DB states pass through in the same frame-end.
REQ-024 key_valid clears on the cycle after key_ack high; key holds value until next accepted press.
REQ-025 key_ack while key_valid low has no effect.
REQ-026 New acceptance in same cycle as key_ack: key_valid stays 1, key updates to new code.

Reset
REQ-027 reset low: pre_cnt=0, r=0, row=4'b1110, state=IDLE, count=0, key=0, key_valid=0, pressed=0, overrun=0, synchronizer=4'b1111, frame accumulator cleared.
REQ-028 Reset asserted mid-debounce or mid-handshake discards pending events; scanning resumes from r=0 after release.

Configuration
REQ-029 Macro KEYPAD_OVERRUN_EN defined: overrun sets when a new press is accepted while key_valid=1 and key_ack=0 that cycle; key overwritten; overrun clears together with key_valid on acknowledge.
REQ-030 Macro KEYPAD_OVERRUN_EN undefined: overrun port present, constant 0, no overrun logic.

Verification (PRE=2, DEB=3 unless stated)
REQ-031 col held 4'b1111 for 100 frames -> key_valid=0, pressed=0, row cycles 1110,1101,1011,0111 every 5 clks.
REQ-032 col[2] low only while row=4'b1101 for 3 frames -> key=4'h6, key_valid=1, pressed=1 one clk after third frame-end tick; key_ack pulse -> key_valid=0 next clk.
REQ-033 Bounce: key 6 present 2 frames, absent 1, present 3 -> exactly one key_valid event, key=4'h6.
REQ-034 Keys 1 (r0,c1) and 14 (r3,c2) both held -> key=4'h1; release all for 3 frames -> pressed=0.
REQ-035 KEYPAD_OVERRUN_EN defined, press/release key 3 then key 9 without ack -> key=4'h9, overrun=1; ack -> key_valid=0, overrun=0; undefined -> overrun stays 0.
REQ-036 reset low during DB_PRESS frame 2 -> all outputs at reset values immediately, no key_valid after release.
